// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: display reads (1-cycle latency, never stalled) > posted CPU writes > CPU reads.
// CPU backpressure is cpu_ready: low while a read is outstanding, the write FIFO is full, or in reset.
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        disp_req,
    input  logic [ADDR_W-1:0]           disp_addr,
    output logic [DATA_W-1:0]           disp_data,
    output logic                        disp_valid,
    input  logic                        cpu_we,
    input  logic                        cpu_re,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic                        cpu_ready,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_rvalid,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        starved
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_PEND = 2'd1;
    localparam logic [1:0] S_RD_DATA = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_disp_valid;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_starved;

    logic w_empty;
    logic w_full;
    logic w_ready;
    logic w_push;
    logic w_rd_accept;
    logic w_pop;
    logic w_rd_issue;

    // Combinational grants are gated by rst so nothing reaches the RAM while in reset.
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_ready     = rst && (r_state == S_IDLE) && !w_full;
    assign w_push      = cpu_we && w_ready;
    assign w_rd_accept = cpu_re && !cpu_we && w_ready;
    assign w_pop       = rst && !disp_req && !w_empty;
    assign w_rd_issue  = rst && !disp_req && w_empty && (r_state == S_RD_PEND);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst && disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (w_pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_fifo_addr[r_rd_ptr];
            mem_wdata = r_fifo_data[r_rd_ptr];
        end else if (w_rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = r_rd_addr;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LVL_W'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= disp_req;
            r_cpu_rvalid <= (r_state == S_RD_DATA);
            case (r_state)
                S_IDLE: begin
                    if (w_rd_accept) begin
                        r_rd_addr <= cpu_addr;
                        r_state   <= S_RD_PEND;
                    end
                end
                S_RD_PEND: begin
                    if (w_rd_issue)
                        r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    r_cpu_rdata <= mem_rdata;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Counts cycles the FIFO head loses its slot to the display; any drain resets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_starved    <= 1'b0;
        end else if (!w_empty && disp_req) begin
            if (r_starve_cnt != CNT_W'(STARVE_LIMIT))
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            if (r_starve_cnt >= CNT_W'(STARVE_LIMIT - 1))
                r_starved <= 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign cpu_ready  = w_ready;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign disp_valid = r_disp_valid;
    assign disp_data  = mem_rdata;
    assign fifo_level = r_level;
    assign starved    = r_starved;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_vram_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    fifo_level;
    logic          starved;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .starved(starved)
    );

    always #5 clk = ~clk;

    // Frame-buffer BRAM: synchronous single port, read data one cycle after a read enable.
    bit [DW-1:0] ram [0:32767];
    bit [DW-1:0] ram_q;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // Reference model: pending writes as a queue, CPU-visible memory image, read in flight.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t           wq[$];
    bit [DW-1:0]   shadow [0:32767];
    int            rd_st;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] rd_exp;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          m_dvalid;
    int            st_cnt;
    logic          m_starved;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        shadow    = ram;
        rd_st     = 0;
        rd_a      = '0;
        rd_exp    = '0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_dvalid  = 1'b0;
        st_cnt    = 0;
        m_starved = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst       = 1'b0;
            disp_req  = 1'($urandom);
            disp_addr = AW'($urandom);
            cpu_we    = 1'($urandom);
            cpu_re    = 1'($urandom);
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
            @(negedge clk);
            chk("rst_ready", cpu_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_dvalid", disp_valid, 0);
            chk("rst_rvalid", cpu_rvalid, 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_level", fifo_level, 0);
            chk("rst_starved", starved, 0);
        end
        model_reset();
        disp_req = 1'b0;
        cpu_we   = 1'b0;
        cpu_re   = 1'b0;
        rst      = 1'b1;
    endtask

    task automatic cycle(input logic d, input logic [AW-1:0] da, input logic we, input logic re,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic          e_rdy;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          acc_w;
        logic          acc_r;
        @(posedge clk);
        #1;
        disp_req  = d;
        disp_addr = da;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(negedge clk);
        e_rdy  = (rd_st == 0) && (wq.size() < DEPTH);
        e_en   = 1'b0;
        e_we   = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        if (d) begin
            e_en   = 1'b1;
            e_addr = da;
        end else if (wq.size() > 0) begin
            e_en   = 1'b1;
            e_we   = 1'b1;
            e_addr = wq[0].a;
            e_wd   = wq[0].d;
        end else if (rd_st == 1) begin
            e_en   = 1'b1;
            e_addr = rd_a;
        end
        chk("cpu_ready", cpu_ready, e_rdy);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("fifo_level", fifo_level, wq.size());
        chk("disp_valid", disp_valid, m_dvalid);
        chk("disp_data", disp_data, ram_q);
        chk("cpu_rvalid", cpu_rvalid, m_rvalid);
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("starved", starved, m_starved);

        acc_w = we && e_rdy;
        acc_r = re && !we && e_rdy;
        if (wq.size() > 0 && d) begin
            if (st_cnt < LIMIT) st_cnt++;
            if (st_cnt == LIMIT) m_starved = 1'b1;
        end else begin
            st_cnt = 0;
        end
        m_rvalid = (rd_st == 2);
        if (rd_st == 2) begin
            m_rdata = rd_exp;
            rd_st   = 0;
        end else if (rd_st == 1 && !d && wq.size() == 0) begin
            rd_st = 2;
        end
        if (!d && wq.size() > 0) void'(wq.pop_front());
        if (acc_w) begin
            wq.push_back('{a, wd});
            shadow[a] = wd;
        end
        if (acc_r) begin
            rd_st  = 1;
            rd_a   = a;
            rd_exp = shadow[a];
        end
        m_dvalid = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        do_reset(3);
        idle(2);

        // posted write drain
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0123, 8'hAA);
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0124, 8'h55);
        idle(2);

        // fill FIFO while display owns every slot, then drain
        for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i), 1'b1, 1'b0, AW'(16'h40 + i), DW'(i + 1));
        idle(5);

        // read-after-write with display toggling
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0010, 8'h3C);
        cycle(1'b1, 15'h5, 1'b0, 1'b1, 15'h0010, '0);
        for (int i = 0; i < 6; i++) cycle(1'(i % 2), AW'(i), 1'b0, 1'b0, '0, '0);
        idle(2);
        chk("raw_rdata", cpu_rdata, 8'h3C);

        // simultaneous write and read: write wins, read held and accepted later
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h0020, 8'h77);
        cycle(1'b0, '0, 1'b0, 1'b1, 15'h0020, '0);
        idle(4);
        chk("wr_rd_rdata", cpu_rdata, 8'h77);

        // starvation becomes sticky
        cycle(1'b1, '0, 1'b1, 1'b0, 15'h0030, 8'h99);
        for (int i = 0; i < LIMIT; i++) cycle(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
        idle(1);
        chk("starved_set", starved, 1);
        idle(3);
        chk("starved_sticky", starved, 1);

        // reset while a read is pending
        cycle(1'b1, '0, 1'b0, 1'b1, 15'h0030, '0);
        cycle(1'b1, '0, 1'b0, 1'b0, '0, '0);
        do_reset(1);
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            int p;
            case ((n / 200) % 4)
                0:       p = 0;
                1:       p = 30;
                2:       p = 70;
                default: p = 95;
            endcase
            if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 99) < p), AW'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)), DW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
